// File: rtl/skinny_masked_pkg.sv
// Shared constants and helpers for the 3-share SKINNY-64 S-box pipeline.
// The S-box splits into two quadratic stages glued together by per-share affine maps.
package skinny_masked_pkg;

  localparam int SBOX_BITS       = 4;
  localparam int SHARES          = 3;
  localparam int RAND_PER_SBOX   = 24;
  localparam int REMASK_PER_SBOX = 8;
  localparam int SBOX_LATENCY    = 5;

  localparam int AFF_IN  = 1;
  localparam int AFF_MID = 3;
  localparam int AFF_OUT = 2;

  // Nibble i holds S(i).
  localparam logic [63:0] SBOX_TABLE = 64'hF7E4_D583_B2A1_096C;

  function automatic logic [3:0] sbox_ref(input logic [3:0] x);
    logic [63:0] t;
    t = SBOX_TABLE;
    return t[{x, 2'b00} +: 4];
  endfunction

  // The constant part of an affine map is added to share 1 only.
  function automatic logic [3:0] skinny_affine(input int num, input logic [3:0] x,
                                               input logic add_c);
    case (num)
      AFF_MID: return {x[2], x[1] ^ add_c, x[0] ^ add_c, x[3]};
      AFF_OUT: return x ^ {2'b00, add_c, add_c};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/SKINNYAffines.sv
// Share-wise affine layer between the quadratic stages; purely combinational.
module SKINNYAffines
  import skinny_masked_pkg::*;
#(
  parameter int NUM = AFF_IN
) (
  input  logic [SHARES-1:0][SBOX_BITS-1:0] x_i,
  output logic [SHARES-1:0][SBOX_BITS-1:0] y_o
);

  always_comb begin
    for (int s = 0; s < SHARES; s++) begin
      y_o[s] = skinny_affine(NUM, x_i[s], s == 0);
    end
  end

endmodule

// File: rtl/q294_2order_en.sv
// Second-order quadratic stage: F(a) = (a2, a1, a0^a3^a2^a3a2, a3^a2^a1^a2a1).
// Cross-share products are masked and registered before any recombination.
module q294_2order_en
  import skinny_masked_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_i,
  input  logic                             en_i,
  input  logic [SHARES-1:0][SBOX_BITS-1:0] a_i,
  input  logic [11:0]                      r_i,
  output logic [SHARES-1:0][SBOX_BITS-1:0] y_o
);

  logic [SHARES-1:0][3:0] inner_d, inner_q;
  logic [SHARES-1:0][3:0] cross_d, cross_q;
  logic [SHARES-1:0]      b3, b2, b1;

  // Masks m0/m1/m2 pair share domains (0,1), (0,2), (1,2).
  function automatic logic [1:0] dom_cross(input logic [2:0] u, input logic [2:0] v,
                                           input logic [2:0] m, input int i);
    case (i)
      0:       return {u[0] & v[1] ^ m[0], u[0] & v[2] ^ m[1]};
      1:       return {u[1] & v[0] ^ m[0], u[1] & v[2] ^ m[2]};
      default: return {u[2] & v[0] ^ m[1], u[2] & v[1] ^ m[2]};
    endcase
  endfunction

  always_comb begin
    b3 = '0;
    b2 = '0;
    b1 = '0;
    for (int s = 0; s < SHARES; s++) begin
      b3[s] = a_i[s][3];
      b2[s] = a_i[s][2];
      b1[s] = a_i[s][1];
    end
    for (int s = 0; s < SHARES; s++) begin
      // Pass-through bits get a ring refresh from r[11:6]; product bits are DOM-masked by r[5:0].
      inner_d[s] = {a_i[s][2] ^ r_i[6 + s] ^ r_i[6 + (s + 1) % 3],
                    a_i[s][1] ^ r_i[9 + s] ^ r_i[9 + (s + 1) % 3],
                    a_i[s][0] ^ a_i[s][3] ^ a_i[s][2] ^ (a_i[s][3] & a_i[s][2]),
                    a_i[s][3] ^ a_i[s][2] ^ a_i[s][1] ^ (a_i[s][2] & a_i[s][1])};
      cross_d[s] = {dom_cross(b3, b2, r_i[2:0], s), dom_cross(b2, b1, r_i[5:3], s)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      inner_q <= '0;
      cross_q <= '0;
    end else if (en_i) begin
      inner_q <= inner_d;
      cross_q <= cross_d;
    end
  end

  always_comb begin
    for (int s = 0; s < SHARES; s++) begin
      y_o[s] = inner_q[s] ^ {2'b00, cross_q[s][3] ^ cross_q[s][2],
                             cross_q[s][1] ^ cross_q[s][0]};
    end
  end

endmodule

// File: rtl/skinny_sbox_masked_slice.sv
// One 3-share SKINNY-64 S-box: five register stages, remask applied on the output load.
module skinny_sbox_masked_slice
  import skinny_masked_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_i,
  input  logic                             en_i,
  input  logic [SHARES-1:0][SBOX_BITS-1:0] x_i,
  input  logic [RAND_PER_SBOX-1:0]         r_i,
  input  logic [REMASK_PER_SBOX-1:0]       rm_i,
  input  logic                             out_load_i,
  output logic [SHARES-1:0][SBOX_BITS-1:0] y_o
);

  logic [SHARES-1:0][SBOX_BITS-1:0] aff_in, s1_q, qa, aff_mid, s3_q, qb, aff_out, s5_d, s5_q;

  SKINNYAffines #(.NUM(AFF_IN)) u_aff_in (.x_i(x_i), .y_o(aff_in));

  q294_2order_en u_qa (
    .clk(clk), .rst_i(rst_i), .en_i(en_i), .a_i(s1_q), .r_i(r_i[11:0]), .y_o(qa)
  );

  SKINNYAffines #(.NUM(AFF_MID)) u_aff_mid (.x_i(qa), .y_o(aff_mid));

  q294_2order_en u_qb (
    .clk(clk), .rst_i(rst_i), .en_i(en_i), .a_i(s3_q), .r_i(r_i[23:12]), .y_o(qb)
  );

  SKINNYAffines #(.NUM(AFF_OUT)) u_aff_out (.x_i(qb), .y_o(aff_out));

  // Bubbles are flushed to zero at the output so idle outputs never carry stale shares.
  always_comb begin
    s5_d = '0;
    if (out_load_i) begin
      s5_d[0] = aff_out[0] ^ rm_i[3:0];
      s5_d[1] = aff_out[1] ^ rm_i[7:4];
      s5_d[2] = aff_out[2] ^ rm_i[3:0] ^ rm_i[7:4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      s1_q <= '0;
      s3_q <= '0;
      s5_q <= '0;
    end else if (en_i) begin
      s1_q <= aff_in;
      s3_q <= aff_mid;
      s5_q <= s5_d;
    end
  end

  assign y_o = s5_q;

endmodule

// File: rtl/skinny_sbox_layer_masked.sv
// NUM_SBOX-wide second-order masked SKINNY-64 S-box layer with enable and valid tracking.
module skinny_sbox_layer_masked
  import skinny_masked_pkg::*;
#(
  parameter int NUM_SBOX = 16
) (
  input  logic                        clk,
  input  logic                        rst_i,
  input  logic                        en,
  input  logic                        in_valid,
  input  logic [4*NUM_SBOX-1:0]       in1,
  input  logic [4*NUM_SBOX-1:0]       in2,
  input  logic [4*NUM_SBOX-1:0]       in3,
  input  logic [24*NUM_SBOX-1:0]      r,
  input  logic [8*NUM_SBOX-1:0]       rm,
  output logic [4*NUM_SBOX-1:0]       out1,
  output logic [4*NUM_SBOX-1:0]       out2,
  output logic [4*NUM_SBOX-1:0]       out3,
  output logic                        out_valid
);

  localparam int LATENCY = SBOX_LATENCY;

  logic [LATENCY-1:0] valid_q, valid_d;

  assign valid_d = {valid_q[LATENCY-2:0], in_valid};

  always_ff @(posedge clk) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (en) begin
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q[LATENCY-1];

  for (genvar k = 0; k < NUM_SBOX; k++) begin : g_sbox
    logic [SHARES-1:0][SBOX_BITS-1:0] x, y;

    assign x = {in3[SBOX_BITS*k +: SBOX_BITS], in2[SBOX_BITS*k +: SBOX_BITS],
                in1[SBOX_BITS*k +: SBOX_BITS]};

    skinny_sbox_masked_slice u_slice (
      .clk       (clk),
      .rst_i     (rst_i),
      .en_i      (en),
      .x_i       (x),
      .r_i       (r[RAND_PER_SBOX*k +: RAND_PER_SBOX]),
      .rm_i      (rm[REMASK_PER_SBOX*k +: REMASK_PER_SBOX]),
      .out_load_i(valid_q[LATENCY-2]),
      .y_o       (y)
    );

    assign out1[SBOX_BITS*k +: SBOX_BITS] = y[0];
    assign out2[SBOX_BITS*k +: SBOX_BITS] = y[1];
    assign out3[SBOX_BITS*k +: SBOX_BITS] = y[2];
  end

endmodule

// File: tb/tb_skinny_sbox_layer_masked.sv
// Directed bench for the masked S-box layer: recombined values, latency, stalls, reset, remask.
module tb_skinny_sbox_layer_masked;

  localparam int NS = 16;
  localparam int W  = 4 * NS;
  localparam logic [63:0] SB_PACK = 64'hF7E4_D583_B2A1_096C;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1, en = 1'b0, in_valid = 1'b0;
  logic [W-1:0]    in1 = '0, in2 = '0, in3 = '0;
  logic [24*NS-1:0] r = '0;
  logic [8*NS-1:0] rm = '0;
  logic [W-1:0]    out1, out2, out3;
  logic            out_valid;

  typedef struct {
    int           due;
    logic [W-1:0] val;
  } tok_t;

  tok_t         exp_q[$];
  int           n_vec = 0, n_err = 0, en_cnt = 0;
  logic         exp_v = 1'b0, zero_chk = 1'b0;
  logic [W-1:0] p1 = '0, p2 = '0, p3 = '0;

  always #5 clk = ~clk;

  skinny_sbox_layer_masked #(.NUM_SBOX(NS)) dut (
    .clk(clk), .rst_i(rst_i), .en(en), .in_valid(in_valid),
    .in1(in1), .in2(in2), .in3(in3), .r(r), .rm(rm),
    .out1(out1), .out2(out2), .out3(out3), .out_valid(out_valid)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] sbox_vec(input logic [W-1:0] x);
    logic [63:0]  t;
    logic [W-1:0] y;
    t = SB_PACK;
    y = '0;
    for (int k = 0; k < NS; k++) y[4*k +: 4] = t[4*x[4*k +: 4] +: 4];
    return y;
  endfunction

  task automatic rand_r();
    for (int i = 0; i < 24 * NS / 32; i++) r[32*i +: 32] = $urandom();
  endtask

  task automatic rand_rm();
    for (int i = 0; i < 8 * NS / 32; i++) rm[32*i +: 32] = $urandom();
  endtask

  task automatic load_shares(input logic [W-1:0] x, input bit rnd);
    if (rnd) begin
      in1 = {$urandom(), $urandom()};
      in2 = {$urandom(), $urandom()};
    end else begin
      in1 = x;
      in2 = '0;
    end
    in3 = x ^ in1 ^ in2;
  endtask

  // One clock: remembers what was driven, then checks outputs against the timing model.
  task automatic tick();
    logic         e_s, v_s, rs_s;
    logic [W-1:0] x_s;
    tok_t         t;
    e_s = en; v_s = in_valid; rs_s = rst_i; x_s = in1 ^ in2 ^ in3;
    @(posedge clk);
    #1;
    if (rs_s) begin
      exp_q.delete();
      exp_v = 1'b0;
      chk("rst_valid", W'(out_valid), '0);
      chk("rst_out", out1 | out2 | out3, '0);
    end else if (!e_s) begin
      chk("hold_valid", W'(out_valid), W'(exp_v));
      chk("hold_s1", out1, p1);
      chk("hold_s2", out2, p2);
      chk("hold_s3", out3, p3);
    end else begin
      en_cnt++;
      if (v_s) begin
        t.due = en_cnt + 4;
        t.val = sbox_vec(x_s);
        exp_q.push_back(t);
      end
      if (exp_q.size() > 0 && exp_q[0].due == en_cnt) begin
        exp_v = 1'b1;
        chk("out_valid", W'(out_valid), W'(1));
        chk("recombined", out1 ^ out2 ^ out3, exp_q[0].val);
        void'(exp_q.pop_front());
      end else begin
        exp_v = 1'b0;
        chk("bubble_valid", W'(out_valid), '0);
        if (zero_chk) chk("bubble_zero", out1 | out2 | out3, '0);
      end
    end
    p1 = out1; p2 = out2; p3 = out3;
  endtask

  logic [24*NS-1:0] rseq[5];
  logic [8*NS-1:0]  rmseq[5];
  logic [W-1:0]     ref1, ref2, ref3, b1, b2, b3, xv, tok1;
  logic [7:0]       jb;

  initial begin
    // reset
    rst_i = 1'b1; en = 1'b0;
    tick(); tick();
    rst_i = 1'b0;

    // single token, all-zero shares and randomness
    en = 1'b1; in_valid = 1'b1; r = '0; rm = '0; zero_chk = 1'b1;
    load_shares('0, 1'b0);
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    zero_chk = 1'b0;

    // back-to-back sweep, lane k carries x+k
    for (int x = 0; x < 16; x++) begin
      for (int k = 0; k < NS; k++) xv[4*k +: 4] = 4'(x + k);
      load_shares(xv, 1'b1);
      rand_r(); rand_rm();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (6) begin rand_r(); rand_rm(); tick(); end

    // lane k carries k
    load_shares(64'hFEDC_BA98_7654_3210, 1'b1);
    rand_r(); rand_rm();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();

    // stall: reference run, then same enabled-cycle randomness with 3 idle cycles
    for (int i = 0; i < 5; i++) begin
      rand_r(); rand_rm();
      rseq[i] = r; rmseq[i] = rm;
    end
    tok1 = {NS{4'h1}};
    load_shares(tok1, 1'b1);
    xv = in1;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 0); r = rseq[i]; rm = rmseq[i];
      tick();
    end
    ref1 = out1; ref2 = out2; ref3 = out3;
    chk("ref_value", ref1 ^ ref2 ^ ref3, {NS{4'h6}});
    in_valid = 1'b0;
    repeat (3) tick();
    in1 = xv; in3 = tok1 ^ in1 ^ in2;
    for (int i = 0; i < 3; i++) begin
      in_valid = (i == 0); r = rseq[i]; rm = rmseq[i];
      tick();
    end
    en = 1'b0; in_valid = 1'b0;
    repeat (3) begin rand_r(); rand_rm(); tick(); end
    en = 1'b1;
    for (int i = 3; i < 5; i++) begin
      r = rseq[i]; rm = rmseq[i];
      tick();
    end
    chk("stall_s1", out1, ref1);
    chk("stall_s2", out2, ref2);
    chk("stall_s3", out3, ref3);
    in_valid = 1'b0;
    repeat (6) tick();

    // reset with three tokens in flight
    for (int i = 0; i < 3; i++) begin
      load_shares({$urandom(), $urandom()}, 1'b1);
      rand_r(); rand_rm();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0; rst_i = 1'b1;
    tick();
    rst_i = 1'b0; zero_chk = 1'b1;
    repeat (3) tick();
    load_shares(64'h0123_4567_89AB_CDEF, 1'b1);
    rand_r(); rand_rm();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    zero_chk = 1'b0;

    // remask sweep on x=F with r held constant
    load_shares({NS{4'hF}}, 1'b1);
    rand_r(); rm = '0; in_valid = 1'b1;
    repeat (6) tick();
    b1 = out1; b2 = out2; b3 = out3;
    for (int j = 0; j < 256; j++) begin
      jb = 8'(j);
      rm = {NS{jb}};
      tick();
      chk("rm_share1", out1 ^ b1, {NS{jb[3:0]}});
      chk("rm_share2", out2 ^ b2, {NS{jb[7:4]}});
      chk("rm_share3", out3 ^ b3, {NS{jb[3:0] ^ jb[7:4]}});
    end
    in_valid = 1'b0;
    repeat (6) tick();

    chk("drain", W'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/skinny_sbox_layer_masked.md
Name: skinny_sbox_layer_masked

Overview:
Parametrised, pipelined, second-order (3-share) masked SKINNY-64 S-box layer with NUM_SBOX parallel 4-bit S-boxes.
- Adds a global pipeline enable, a valid shadow pipeline, registered outputs and a per-S-box output remask.
- Sits between the masked state register and the ShiftRows/MixColumns datapath of the threshold SKINNY round.
- Core decomposition per S-box is unchanged: affine(num=1) → Q294 → affine(num=3) → Q294 → affine(num=2).

Parameters:
- NUM_SBOX, 16, number of parallel 4-bit S-boxes; legal range 1..16.
- LATENCY, 5, fixed pipeline depth in enabled cycles. Localparam, not overridable.

Ports:
- clk  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- en  in  1  pipeline advance. When 0, every register holds.
- in_valid  in  1  marks the current input shares as a real token.
- in1  in  4*NUM_SBOX  share 1. S-box k uses bits [4k+3:4k].
- in2  in  4*NUM_SBOX  share 2.
- in3  in  4*NUM_SBOX  share 3.
- r  in  24*NUM_SBOX  fresh randomness for the two Q294 stages. S-box k uses slice [24k+23:24k]: low 12 bits for stage A, high 12 bits for stage B.
- rm  in  8*NUM_SBOX  output remask. S-box k uses [8k+7:8k].
- out1  out  4*NUM_SBOX  registered output share 1.
- out2  out  4*NUM_SBOX  registered output share 2.
- out3  out  4*NUM_SBOX  registered output share 3.
- out_valid  out  1  out1..out3 hold a real token.

Behaviour:
- Pipeline stages per S-box, each register loaded only when en=1:
  - S1: input-affine result register.
  - S2: Q294 stage A internal register; consumes r[11:0] in that cycle.
  - S3: middle-affine result register.
  - S4: Q294 stage B internal register; consumes r[23:12].
  - S5: output register, loaded with OutAff ^ remask:
    - share1 ^= rm[3:0]
    - share2 ^= rm[7:4]
    - share3 ^= rm[3:0]^rm[7:4]
- Latency: a token presented with en=1 appears on out* exactly 5 enabled cycles later. Cycles with en=0 do not count.
- Correctness: out1^out2^out3 = S(in1^in2^in3) per nibble, with S = {C,6,9,0,1,A,2,B,3,8,5,D,4,E,7,F}.
- Remask must not change the unmasked value.
- Valid pipeline:
  - 5-bit shift register fed by in_valid; advances only on en=1. out_valid is its last bit.
  - Data registers load on every en=1 cycle regardless of in_valid; bubbles carry don't-care shares.
- Randomness rules:
  - r and rm are sampled only in cycles with en=1.
  - With en=0 they are ignored and no randomness is consumed.
  - The same r bits are never reused across stages: the stage A and stage B slices are disjoint.
- Reset (rst_i=1 at a clk edge):
  - All data registers, including Q294 internals, go to 0.
  - Valid shift register goes to 0; out1..out3=0 and out_valid=0 after the edge.
  - rst_i has priority over en.
  - Reset mid-operation drops all in-flight tokens; no partial token emerges afterwards.
- Simultaneous events:
  - en=1 with in_valid=1 while out_valid=1: the new token enters and the old one leaves in the same edge (full throughput, 1 token/cycle).
  - en toggling: tokens resume exactly where they stalled; shares are unchanged while held.
- No combinational path from in*/r/rm to any output. Glitch isolation is provided by the stage registers.

Decomposition:
- Package skinny_masked_pkg holds:
  - SBOX_BITS=4, SHARES=3, RAND_PER_SBOX=24, REMASK_PER_SBOX=8, SBOX_LATENCY=5.
  - The reference S-box table, for assertions and scoreboard.
  - Affine selector constants AFF_IN=1, AFF_MID=3, AFF_OUT=2.
- Sub-module skinny_sbox_masked_slice implements one 3-share S-box with en and rst_i, instantiated NUM_SBOX times by generate.
- The slice uses SKINNYAffines and an enable/reset-capable Q294 variant, q294_2order_en.
- The valid shift register lives in the top level.

Test Plan:
1. Reset then NUM_SBOX=1, en=1, in_valid=1, shares (0,0,0), r=0, rm=0 → after 5 cycles out_valid=1 and out1^out2^out3=C; all outputs 0 before that.
2. Exhaustive sweep of x=0..F, each split with random shares, random r/rm every cycle, back-to-back tokens → recombined outputs C,6,9,0,1,A,2,B,3,8,5,D,4,E,7,F in order on consecutive cycles.
3. NUM_SBOX=16, input nibbles k=0..F in lane k → lane k recombines to S(k); out_valid high for exactly 1 cycle per token.
4. Stall: token x=1 in, en=0 for 3 cycles at stage 3 with r/rm toggling → out appears after 5 enabled cycles (8 total); recombined value is 6, shares identical to an unstalled run with the same enabled-cycle randomness.
5. Reset mid-flight: 3 tokens in flight, rst_i=1 for 1 cycle with en=1 → out_valid stays 0 and out*=0 until a new token completes 5 cycles later.
6. Remask check: fixed input x=F and fixed r, rm swept over 0x00..0xFF → recombined output always F; out1 and out2 vary by rm[3:0] and rm[7:4] respectively.
